// File: rtl/master_rx_port.sv
// Master-side serial receive port: assembles LANES-wide beats into words after a
// valid/ready handshake and buffers them in a show-ahead FIFO drained by the bus master.
module master_rx_port #(
  parameter int DATA_LEN   = 8,
  parameter int LANES      = 1,
  parameter int BURST_MAX  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          tx_done,
  input  logic [1:0]                    instruction,
  input  logic [$clog2(BURST_MAX):0]    burst_len,
  input  logic [LANES-1:0]              rx_data,
  input  logic                          slave_valid,
  output logic                          master_ready,
  output logic [DATA_LEN-1:0]           data,
  output logic                          data_valid,
  input  logic                          data_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_done,
  output logic                          busy
);

  localparam int BEATS  = DATA_LEN / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LEN_W  = $clog2(BURST_MAX) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HANDSHAKE,
    RECEIVE
  } state_t;

  state_t              state_reg, state_next;
  logic [BEAT_W-1:0]   beat_reg, beat_next, beat_sel;
  logic [LEN_W-1:0]    word_cnt_reg, word_cnt_next;
  logic [LEN_W-1:0]    len_reg, len_next, len_clamped;
  logic                push_reg, push_next;
  logic                rx_done_reg, rx_done_next;
  logic                ready_reg, ready_next;
  logic                capture;
  logic [DATA_LEN-1:0] word_reg, word_next;

  logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [DATA_LEN-1:0] head_reg, head_next;
  logic                pop;

  always_comb begin
    if (burst_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (burst_len > LEN_W'(BURST_MAX)) begin
      len_clamped = LEN_W'(BURST_MAX);
    end else begin
      len_clamped = burst_len;
    end
  end

  // Each beat slot of the word register loads only when its beat index is captured.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_slot
      localparam int POS = (MSB_FIRST != 0) ? (DATA_LEN - (gi + 1) * LANES) : (gi * LANES);
      assign word_next[POS +: LANES] = (capture && (beat_sel == BEAT_W'(gi))) ?
                                       rx_data : word_reg[POS +: LANES];
    end
  endgenerate

  always_comb begin
    pop         = data_ack && (count_reg != '0);
    wr_ptr_next = push_reg ? (wr_ptr_reg + PTR_W'(1)) : wr_ptr_reg;
    rd_ptr_next = pop ? (rd_ptr_reg + PTR_W'(1)) : rd_ptr_reg;
    count_next  = count_reg;
    if (push_reg && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!push_reg && pop) begin
      count_next = count_reg - CNT_W'(1);
    end
    // The head register is reloaded every cycle; bypass the word being written
    // when it becomes the new head.
    if (count_next == '0) begin
      head_next = '0;
    end else if (push_reg && (rd_ptr_next == wr_ptr_reg)) begin
      head_next = word_reg;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  // A completed word spends one cycle in word_reg before it is written; the slot
  // was reserved by the handshake, so master_ready stays low until the push lands.
  always_comb begin
    state_next    = state_reg;
    beat_next     = beat_reg;
    word_cnt_next = word_cnt_reg;
    len_next      = len_reg;
    push_next     = 1'b0;
    rx_done_next  = 1'b0;
    capture       = 1'b0;
    beat_sel      = beat_reg;
    if (push_reg) begin
      word_cnt_next = word_cnt_reg + LEN_W'(1);
      if (word_cnt_next >= len_reg) begin
        state_next   = IDLE;
        rx_done_next = 1'b1;
      end else begin
        state_next = WAIT_HANDSHAKE;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if ((instruction == 2'b11) && tx_done && !rx_done_reg) begin
            state_next    = WAIT_HANDSHAKE;
            word_cnt_next = '0;
            len_next      = len_clamped;
            beat_next     = '0;
          end
        end
        WAIT_HANDSHAKE: begin
          if (slave_valid && ready_reg) begin
            capture  = 1'b1;
            beat_sel = '0;
            if (BEATS == 1) begin
              push_next = 1'b1;
            end else begin
              state_next = RECEIVE;
              beat_next  = BEAT_W'(1);
            end
          end
        end
        RECEIVE: begin
          capture = 1'b1;
          if (beat_reg == BEAT_W'(BEATS - 1)) begin
            push_next = 1'b1;
            beat_next = '0;
          end else begin
            beat_next = beat_reg + BEAT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
    ready_next = (state_next != RECEIVE) && !push_next &&
                 (count_next < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      beat_reg     <= '0;
      word_cnt_reg <= '0;
      len_reg      <= LEN_W'(1);
      push_reg     <= 1'b0;
      rx_done_reg  <= 1'b0;
      ready_reg    <= 1'b1;
      word_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      beat_reg     <= beat_next;
      word_cnt_reg <= word_cnt_next;
      len_reg      <= len_next;
      push_reg     <= push_next;
      rx_done_reg  <= rx_done_next;
      ready_reg    <= ready_next;
      word_reg     <= word_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_reg) begin
      mem[wr_ptr_reg] <= word_reg;
    end
  end

  assign master_ready = ready_reg;
  assign data         = head_reg;
  assign data_valid   = (count_reg != '0);
  assign fifo_count   = count_reg;
  assign rx_done      = rx_done_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_master_rx_port.sv
// Bench for master_rx_port: directed steps plus randomized bursts checked against
// a queue-based model of accepted words; a second instance covers 2-lane MSB-first.
module tb_master_rx_port;

  localparam int TMO = 200;

  logic       clk;
  logic       reset_n;
  logic       tx_done;
  logic [1:0] instruction;
  logic [2:0] burst_len;
  logic       data_ack;

  logic       rx_data, slave_valid, master_ready, data_valid, rx_done, busy;
  logic [7:0] data;
  logic [2:0] fifo_count;

  logic [1:0] rx_data2;
  logic       slave_valid2, master_ready2, data_valid2, rx_done2, busy2;
  logic [7:0] data2;
  logic [2:0] fifo_count2;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done2_cnt = 0;
  int popped = 0;
  bit sent_done;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

  master_rx_port u_dut (
    .clk(clk), .reset_n(reset_n), .tx_done(tx_done), .instruction(instruction),
    .burst_len(burst_len), .rx_data(rx_data), .slave_valid(slave_valid),
    .master_ready(master_ready), .data(data), .data_valid(data_valid),
    .data_ack(data_ack), .fifo_count(fifo_count), .rx_done(rx_done), .busy(busy)
  );

  master_rx_port #(.DATA_LEN(8), .LANES(2), .BURST_MAX(4), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .tx_done(tx_done), .instruction(instruction),
    .burst_len(burst_len), .rx_data(rx_data2), .slave_valid(slave_valid2),
    .master_ready(master_ready2), .data(data2), .data_valid(data_valid2),
    .data_ack(data_ack), .fifo_count(fifo_count2), .rx_done(rx_done2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done === 1'b1) done_cnt++;
    if (rx_done2 === 1'b1) done2_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue_read(input int len);
    @(negedge clk);
    instruction = 2'b11;
    tx_done     = 1'b1;
    burst_len   = 3'(len);
    @(negedge clk);
    instruction = 2'b00;
    tx_done     = 1'b0;
    burst_len   = 3'($urandom_range(0, 7));
  endtask

  // Slave for the 1-lane LSB-first port: bit k of the word goes out on beat k.
  task automatic send_word(input logic [7:0] w, input int abort_beat, input bit ack_on_push,
                           output bit ok);
    int n;
    ok = 1'b0;
    @(negedge clk);
    slave_valid = 1'b1;
    rx_data     = w[0];
    n = 0;
    while (master_ready !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (master_ready !== 1'b1) begin
      check("handshake_ready", master_ready, 1);
      slave_valid = 1'b0;
      return;
    end
    exp_q.push_back(w);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == abort_beat) begin
        reset_n     = 1'b0;
        slave_valid = 1'b0;
        return;
      end
      slave_valid = 1'($urandom);
      rx_data     = w[k];
    end
    @(negedge clk);
    slave_valid = 1'b0;
    rx_data     = 1'($urandom);
    if (ack_on_push) begin
      data_ack = 1'b1;
      check("simul_head", data, exp_q[0]);
      void'(exp_q.pop_front());
      popped++;
      @(negedge clk);
      data_ack = 1'b0;
    end
    ok = 1'b1;
  endtask

  // Slave for the 2-lane MSB-first port: top bit pair first.
  task automatic send_word2(input logic [7:0] w, output bit ok);
    int n;
    ok = 1'b0;
    @(negedge clk);
    slave_valid2 = 1'b1;
    rx_data2     = 2'(w >> 6);
    n = 0;
    while (master_ready2 !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (master_ready2 !== 1'b1) begin
      check("handshake2_ready", master_ready2, 1);
      slave_valid2 = 1'b0;
      return;
    end
    exp2_q.push_back(w);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      slave_valid2 = 1'b0;
      rx_data2     = 2'(w >> (6 - 2 * k));
    end
    @(negedge clk);
    rx_data2 = 2'b00;
    ok = 1'b1;
  endtask

  task automatic pop_one();
    if (exp_q.size() == 0) begin
      check("pop_spurious", data_valid, 0);
    end else begin
      check("pop_order", data, exp_q[0]);
      void'(exp_q.pop_front());
      popped++;
    end
  endtask

  task automatic drain(input int pct);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (sent_done) break;
      data_ack = ($urandom_range(0, 99) < pct);
      if (data_ack && data_valid === 1'b1) pop_one();
    end
    data_ack = 1'b0;
  endtask

  task automatic drain_all();
    @(negedge clk);
    for (int c = 0; c < 50 && data_valid === 1'b1; c++) begin
      data_ack = 1'b1;
      pop_one();
      @(negedge clk);
    end
    data_ack = 1'b0;
    check("drain_count", fifo_count, exp_q.size());
  endtask

  initial begin : main
    int  len, eff, pct, d0, n2;
    bit  ok;
    reset_n = 1'b0; tx_done = 1'b0; instruction = 2'b00; burst_len = 3'd0; data_ack = 1'b0;
    rx_data = 1'b0; slave_valid = 1'b0; rx_data2 = 2'b00; slave_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", master_ready, 1);
    check("rst_valid", data_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data, 0);
    check("rst_done", rx_done, 0);
    reset_n = 1'b1;

    // Non-read instruction and a read without tx_done must not start anything.
    @(negedge clk); instruction = 2'b10; tx_done = 1'b1;
    @(negedge clk); instruction = 2'b11; tx_done = 1'b0;
    @(negedge clk); instruction = 2'b00;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_valid", data_valid, 0);

    // Single word with latency and rx_done pulse timing.
    d0 = done_cnt;
    issue_read(1);
    check("single_busy", busy, 1);
    send_word(8'hA5, -1, 1'b0, ok);
    check("lat_not_yet", data_valid, 0);
    @(negedge clk);
    check("lat_valid", data_valid, 1);
    check("lat_data", data, 8'hA5);
    check("lat_done", rx_done, 1);
    check("lat_count", fifo_count, 1);
    @(negedge clk);
    check("done_one_cycle", rx_done, 0);
    check("single_idle", busy, 0);
    @(negedge clk);
    check("single_done_cnt", done_cnt - d0, 1);
    drain_all();

    // Backpressure: fill the FIFO, then a second read stalls until a pop.
    popped = 0;
    issue_read(4);
    for (int i = 0; i < 4; i++) send_word(8'($urandom), -1, 1'b0, ok);
    repeat (3) @(negedge clk);
    check("bp_full_count", fifo_count, exp_q.size());
    check("bp_ready_low", master_ready, 0);
    issue_read(2);
    check("bp_busy", busy, 1);
    sent_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 2; i++) send_word(8'($urandom), -1, 1'b0, ok);
        sent_done = 1'b1;
      end
      begin
        repeat (6) @(negedge clk);
        check("bp_stall_ready", master_ready, 0);
        check("bp_stall_count", fifo_count, exp_q.size());
        drain(100);
      end
    join
    repeat (3) @(negedge clk);
    drain_all();
    check("bp_total_popped", popped, 6);

    // Pop in the same cycle as a push: occupancy must not change.
    issue_read(4);
    for (int i = 0; i < 3; i++) send_word(8'($urandom), -1, 1'b0, ok);
    send_word(8'($urandom), -1, 1'b1, ok);
    check("simul_count", fifo_count, exp_q.size());
    repeat (2) @(negedge clk);
    drain_all();

    // Randomized bursts, including out-of-range lengths, with random draining.
    for (int b = 0; b < 16; b++) begin
      len = $urandom_range(0, 7);
      eff = (len == 0) ? 1 : ((len > 4) ? 4 : len);
      case ($urandom_range(0, 2))
        0:       pct = 35;
        1:       pct = 70;
        default: pct = 100;
      endcase
      d0 = done_cnt;
      issue_read(len);
      sent_done = 1'b0;
      fork
        begin
          for (int i = 0; i < eff; i++) begin
            send_word(8'($urandom), -1, 1'b0, ok);
            if (!ok) break;
          end
          sent_done = 1'b1;
        end
        drain(pct);
      join
      repeat (3) @(negedge clk);
      check("rnd_done", done_cnt - d0, 1);
      check("rnd_idle", busy, 0);
      check("rnd_count", fifo_count, exp_q.size());
      check("rnd_ready", master_ready, (exp_q.size() < 4) ? 1 : 0);
    end
    drain_all();

    // Two lanes, MSB first, burst of three on the second instance.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    d0 = done2_cnt;
    issue_read(3);
    send_word2(8'h12, ok);
    send_word2(8'h34, ok);
    repeat (3) @(negedge clk);
    check("msb_no_early_done", done2_cnt - d0, 0);
    send_word2(8'h56, ok);
    repeat (3) @(negedge clk);
    check("msb_done", done2_cnt - d0, 1);
    check("msb_count", fifo_count2, exp2_q.size());
    n2 = 0;
    @(negedge clk);
    for (int c = 0; c < 10 && data_valid2 === 1'b1; c++) begin
      data_ack = 1'b1;
      if (exp2_q.size() == 0) begin
        check("msb_spurious", data_valid2, 0);
      end else begin
        check("msb_order", data2, exp2_q[0]);
        void'(exp2_q.pop_front());
      end
      n2++;
      @(negedge clk);
    end
    data_ack = 1'b0;
    check("msb_pops", n2, 3);

    // Reset at beat 3 of word 2, then a zero-length read still moves one word.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    issue_read(3);
    send_word(8'($urandom), -1, 1'b0, ok);
    send_word(8'($urandom), 3, 1'b0, ok);
    #1;
    exp_q.delete();
    check("mid_rst_count", fifo_count, exp_q.size());
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", master_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    d0 = done_cnt;
    issue_read(0);
    send_word(8'h3C, -1, 1'b0, ok);
    repeat (3) @(negedge clk);
    check("zero_len_done", done_cnt - d0, 1);
    check("zero_len_idle", busy, 0);
    check("zero_len_count", fifo_count, exp_q.size());
    check("zero_len_data", data, 8'h3C);
    drain_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
